// File: rtl/memory_unit_pkg.sv
// Shared encodings for the memory unit and the load/store buffer.
package memory_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_FETCH = 2'd3
  } mem_state_e;

  localparam logic [1:0]  LEN_BYTE        = 2'b00;
  localparam logic [1:0]  LEN_HALF        = 2'b01;
  localparam logic [1:0]  LEN_WORD        = 2'b10;
  localparam logic [31:0] IO_MASK_DEFAULT = 32'h0003_0000;

  // The reserved length code is treated as a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_unit.sv
// Byte-serial memory controller: arbitrates LSB and fetch requests onto the 8-bit
// RAM/IO bus and assembles little-endian results with a one-cycle completion pulse.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int          LSB_CAP_BIT = 3,
  parameter logic [31:0] IO_MASK     = IO_MASK_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   lsb_req,
  input  logic [LSB_CAP_BIT-1:0] lsb_pos,
  input  logic                   lsb_ls,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_addr,
  input  logic [31:0]            lsb_wdata,
  output logic                   lsb_busy,
  output logic                   lsb_finished,
  output logic [31:0]            lsb_rdata,
  output logic [LSB_CAP_BIT-1:0] lsb_done_pos,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_done,
  output logic [31:0]            if_inst,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  mem_state_e             state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [2:0]             n_q, n_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [LSB_CAP_BIT-1:0] pos_q, pos_d;
  logic [31:0]            acc_q, acc_d;
  logic                   clear_seen_q, clear_seen_d;
  logic                   lsb_finished_q, lsb_finished_d;
  logic [31:0]            lsb_rdata_q, lsb_rdata_d;
  logic [LSB_CAP_BIT-1:0] lsb_done_pos_q, lsb_done_pos_d;
  logic                   if_done_q, if_done_d;
  logic [31:0]            if_inst_q, if_inst_d;
  logic [7:0]             din_hold_q, din_hold_d;
  logic                   hold_valid_q, hold_valid_d;

  logic [7:0]  rx_byte;
  logic [1:0]  byte_idx;
  logic [31:0] acc_next;
  logic [31:0] wdata_shift;
  logic [31:0] cur_addr;
  logic        io_region;
  logic        store_ok;

  // A byte returned while frozen is parked so it is not lost when the bus moves on.
  assign rx_byte     = hold_valid_q ? din_hold_q : mem_din;
  assign byte_idx    = k_q[1:0] - 2'd1;
  assign acc_next    = acc_q | ({24'd0, rx_byte} << {byte_idx, 3'b000});
  assign wdata_shift = wdata_q >> {k_q[1:0], 3'b000};
  assign cur_addr    = addr_q + {29'd0, k_q};
  assign io_region   = (addr_q & IO_MASK) == IO_MASK;
  assign store_ok    = !(io_region && io_buffer_full);

  assign lsb_busy     = (state_q != ST_IDLE);
  assign lsb_finished = lsb_finished_q;
  assign lsb_rdata    = lsb_rdata_q;
  assign lsb_done_pos = lsb_done_pos_q;
  assign if_done      = if_done_q;
  assign if_inst      = if_inst_q;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    n_d            = n_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    pos_d          = pos_q;
    acc_d          = acc_q;
    clear_seen_d   = clear_seen_q;
    lsb_finished_d = 1'b0;
    lsb_rdata_d    = lsb_rdata_q;
    lsb_done_pos_d = lsb_done_pos_q;
    if_done_d      = 1'b0;
    if_inst_d      = if_inst_q;
    din_hold_d     = din_hold_q;
    hold_valid_d   = 1'b0;
    mem_a          = 32'd0;
    mem_dout       = 8'd0;
    mem_wr         = 1'b0;

    case (state_q)
      ST_LOAD, ST_FETCH: begin
        if (k_q < n_q) mem_a = cur_addr;
      end
      ST_STORE: begin
        mem_a    = cur_addr;
        mem_dout = wdata_shift[7:0];
        mem_wr   = rdy_in && store_ok;
      end
      default: ;
    endcase

    if (!rdy_in) begin
      lsb_finished_d = lsb_finished_q;
      if_done_d      = if_done_q;
      hold_valid_d   = hold_valid_q;
      if (!hold_valid_q) begin
        din_hold_d   = mem_din;
        hold_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!clear) begin
            if (lsb_req) begin
              addr_d       = lsb_addr;
              n_d          = len_to_bytes(lsb_len);
              wdata_d      = lsb_wdata;
              pos_d        = lsb_pos;
              k_d          = 3'd0;
              acc_d        = 32'd0;
              clear_seen_d = 1'b0;
              state_d      = lsb_ls ? ST_STORE : ST_LOAD;
            end else if (if_req) begin
              addr_d  = if_addr;
              n_d     = 3'd4;
              k_d     = 3'd0;
              acc_d   = 32'd0;
              state_d = ST_FETCH;
            end
          end
        end
        ST_LOAD, ST_FETCH: begin
          if (clear) begin
            state_d = ST_IDLE;
          end else begin
            if (k_q != 3'd0) acc_d = acc_next;
            if (k_q == n_q) begin
              state_d = ST_IDLE;
              if (state_q == ST_LOAD) begin
                lsb_finished_d = 1'b1;
                lsb_rdata_d    = acc_next;
                lsb_done_pos_d = pos_q;
              end else begin
                if_done_d = 1'b1;
                if_inst_d = acc_next;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        ST_STORE: begin
          // Stores cannot be undone on the bus, so a flush only silences the pulse.
          if (clear) clear_seen_d = 1'b1;
          if (store_ok) begin
            if (k_q == n_q - 3'd1) begin
              state_d = ST_IDLE;
              if (!clear_seen_q && !clear) begin
                lsb_finished_d = 1'b1;
                lsb_rdata_d    = 32'd0;
                lsb_done_pos_d = pos_q;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= ST_IDLE;
      k_q            <= 3'd0;
      n_q            <= 3'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      pos_q          <= '0;
      acc_q          <= 32'd0;
      clear_seen_q   <= 1'b0;
      lsb_finished_q <= 1'b0;
      lsb_rdata_q    <= 32'd0;
      lsb_done_pos_q <= '0;
      if_done_q      <= 1'b0;
      if_inst_q      <= 32'd0;
      din_hold_q     <= 8'd0;
      hold_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      n_q            <= n_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      pos_q          <= pos_d;
      acc_q          <= acc_d;
      clear_seen_q   <= clear_seen_d;
      lsb_finished_q <= lsb_finished_d;
      lsb_rdata_q    <= lsb_rdata_d;
      lsb_done_pos_q <= lsb_done_pos_d;
      if_done_q      <= if_done_d;
      if_inst_q      <= if_inst_d;
      din_hold_q     <= din_hold_d;
      hold_valid_q   <= hold_valid_d;
    end
  end

endmodule
